system_0_sysid_checker: RTL and testbench

//  Avalon-MM read master that interrogates the system ID slave (control_slave, 2 words).
//  It reads word 0 (system ID) and then word 1 (timestamp), and compares each against expected values.
//  It latches the results for the status/LED logic of system_0.
//  It runs once after reset and is re-triggerable by a start pulse.

---
 rtl/system_0_sysid_checker.sv | 127 ++++++++++++
 tb/tb_system_0_sysid_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/system_0_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words once after
// reset (or on a start pulse), compares them against expected values and holds the verdict.
module system_0_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1561468937,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN} state_e;

  // Counter holds cycles already spent in WAIT; the last allowed WAIT cycle is LIMIT-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        arm_q, arm_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, to_q, to_d;
  logic [31:0] id_val_q, id_val_d, ts_val_q, ts_val_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      arm_q    <= AUTO_START;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      to_q     <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      to_q     <= to_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    arm_d       = arm_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    to_d        = to_q;
    id_val_d    = id_val_q;
    ts_val_d    = ts_val_q;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || arm_q) begin
          arm_d   = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          to_d    = 1'b0;
          state_d = ID_REQ;
        end
      end
      ID_REQ: begin
        avm_read = 1'b1;
        cnt_d    = '0;
        if (!avm_waitrequest) state_d = ID_WAIT;
      end
      ID_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A valid arriving on the limit cycle still counts as a response.
        if (avm_readdatavalid) begin
          id_val_d = avm_readdata;
          id_ok_d  = (avm_readdata == EXPECTED_ID);
          state_d  = TS_REQ;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = FIN;
        end
      end
      TS_REQ: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        cnt_d       = '0;
        if (!avm_waitrequest) state_d = TS_WAIT;
      end
      TS_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (avm_readdatavalid) begin
          ts_val_d = avm_readdata;
          ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
          state_d  = FIN;
        end else if (cnt_q == CNT_LAST) begin
          to_d    = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = to_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_system_0_sysid_checker.sv
// Directed bench for system_0_sysid_checker: behavioural sysid slave plus a
// scoreboard of expected check results popped at each done pulse.
module tb_system_0_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1561468937;
  localparam int          TO     = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  system_0_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  // slave configuration
  int          ws = 0, lat0 = 1, lat1 = 1;
  bit          no_resp0 = 0, stray = 0;
  logic [31:0] id_data = 32'd0, ts_data = 32'd1561468937;
  // slave / monitor state
  int          stall = 0, pend = 0, viol = 0, acc1 = 0;
  logic [31:0] pend_data = '0;
  logic        p_read = 1'b0, p_addr = 1'b0;

  int checks = 0, failures = 0;

  typedef struct {
    logic        idok, tsok, to;
    logic [31:0] idv, tsv;
    int          lat;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] last_id = '0, last_ts = '0;

  // Slave acts on the falling edge; waitrequest/readdatavalid are stable across each rising edge.
  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      avm_waitrequest = 0; avm_readdatavalid = 0; stall = 0; pend = 0; p_read = 0;
    end else begin
      if (p_read && avm_waitrequest && (!avm_read || avm_address !== p_addr)) viol++;
      if (p_read && !avm_waitrequest && p_addr) acc1++;
      p_read = avm_read; p_addr = avm_address;
      avm_readdatavalid = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin avm_readdatavalid = 1; avm_readdata = pend_data; end
      end
      if (stray) begin avm_readdatavalid = 1; avm_readdata = 32'hDEAD_BEEF; stray = 0; end
      if (avm_read) begin
        if (stall < ws) begin avm_waitrequest = 1; stall++; end
        else begin
          avm_waitrequest = 0; stall = 0;
          if (avm_address) begin pend = lat1; pend_data = ts_data; end
          else if (!no_resp0) begin pend = lat0; pend_data = id_data; end
        end
      end else begin
        avm_waitrequest = 0; stall = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of the next check for the current slave configuration.
  task automatic push_exp();
    exp_t e;
    if (no_resp0 || lat0 > TO) begin
      e.idok = 0; e.tsok = 0; e.to = 1; e.idv = last_id; e.tsv = last_ts;
      e.lat = 1 + (ws + 1) + TO;
    end else begin
      e.idv = id_data; e.tsv = ts_data; e.to = 0;
      e.idok = (id_data == EXP_ID); e.tsok = (ts_data == EXP_TS);
      e.lat = 1 + (ws + 1) + lat0 + (ws + 1) + lat1;
      last_id = id_data; last_ts = ts_data;
    end
    sb.push_back(e);
  endtask

  // Counts rising edges (the first one samples start/auto-start) until done.
  task automatic run_check(input string tag, input int busy_start_at, input bit fin_start);
    exp_t e;
    int   n = 0;
    do begin
      @(posedge clock); #1;
      start = 0;
      n++;
      if (n == 1) chk({tag, ".cleared"}, {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
      if (n == busy_start_at) start = 1;
    end while (!done && n < 200);
    e = sb.pop_front();
    chk({tag, ".done"}, done, 1);
    chk({tag, ".lat"}, n, e.lat);
    chk({tag, ".id_ok"}, id_ok, e.idok);
    chk({tag, ".ts_ok"}, ts_ok, e.tsok);
    chk({tag, ".timeout"}, timeout_err, e.to);
    chk({tag, ".id_value"}, id_value, e.idv);
    chk({tag, ".ts_value"}, ts_value, e.tsv);
    if (fin_start) start = 1;
    @(posedge clock); #1;
    start = 0;
    chk({tag, ".done_pulse"}, {done, busy}, 0);
    @(posedge clock); #1;
    chk({tag, ".idle"}, {done, busy}, 0);
    chk({tag, ".hold_id"}, id_value, e.idv);
  endtask

  task automatic kick();
    @(posedge clock); #1;
    start = 1;
  endtask

  initial begin
    int a1;
    #1;
    chk("reset.ctl", {26'd0, avm_read, avm_address, busy, done, id_ok, ts_ok}, 0);
    chk("reset.to", timeout_err, 0);
    chk("reset.vals", id_value | ts_value, 0);
    repeat (3) @(posedge clock);
    chk("reset.hold", {30'd0, busy, done}, 0);

    // auto-start after reset, zero-wait slave
    push_exp();
    @(negedge clock); reset_n = 1;
    run_check("auto", 0, 0);

    ts_data = 32'h5D11_0000; push_exp(); kick();
    run_check("bad_ts", 0, 0);
    ts_data = EXP_TS;

    ws = 10; push_exp(); kick();
    run_check("stall10", 0, 0);
    ws = 0;

    no_resp0 = 1; a1 = acc1; push_exp(); kick();
    run_check("timeout", 0, 0);
    chk("timeout.no_addr1", acc1, a1);
    no_resp0 = 0;

    lat0 = TO; push_exp(); kick();
    run_check("valid_at_limit", 0, 0);
    lat0 = TO + 1; push_exp(); kick();
    run_check("valid_late", 0, 0);
    lat0 = 1;

    stray = 1;
    repeat (3) @(posedge clock); #1;
    chk("stray.id", id_value, last_id);
    chk("stray.busy", busy, 0);

    // start while busy is dropped; start on the FIN cycle is dropped too
    push_exp(); kick();
    run_check("busy_start", 2, 1);
    repeat (2) @(posedge clock); #1;
    chk("busy_start.no_rerun", {30'd0, busy, done}, 0);
    push_exp(); kick();
    run_check("restart", 0, 0);

    // reset in TS_WAIT
    id_data = 32'h1234; lat1 = 5; kick();
    @(posedge clock); #1 start = 0;
    repeat (3) @(posedge clock); #1;
    chk("rst_mid.busy_before", busy, 1);
    reset_n = 0; #1;
    chk("rst_mid.ctl", {26'd0, avm_read, avm_address, busy, done, id_ok, ts_ok}, 0);
    chk("rst_mid.vals", {id_value, ts_value, timeout_err} == '0, 1);
    id_data = 32'd0; lat1 = 1; last_id = '0; last_ts = '0;
    repeat (2) @(posedge clock);
    push_exp();
    @(negedge clock); reset_n = 1;
    run_check("rst_rerun", 0, 0);

    chk("avalon_stable", viol, 0);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
